// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network run sequencer.
package snn_pkg;
    localparam int STEP_W_DEF   = 8;
    localparam int CYC_W_DEF    = 4;
    localparam int CNT_W_DEF    = 8;
    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        HOLD,
        DONE
    } run_state_t;
endpackage

// File: rtl/snn_spike_counter.sv
// Per-neuron rising-edge detector feeding a saturating spike counter.
module snn_spike_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             prev_clr,
    input  logic             enable,
    input  logic             spike,
    output logic [CNT_W-1:0] count
);
    logic prev_q;
    logic rise;

    assign rise = spike & ~prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            count  <= '0;
        end else begin
            prev_q <= prev_clr ? 1'b0 : spike;
            if (clear)
                count <= '0;
            else if (enable && rise && (count != '1))
                count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/snn_run_sequencer.sv
// Run-control FSM: clears the network, then feeds one spike vector per
// timestep and counts layer-2 output spikes.
module snn_run_sequencer
    import snn_pkg::*;
#(
    parameter int M1     = 24,
    parameter int N2     = 2,
    parameter int STEP_W = STEP_W_DEF,
    parameter int CYC_W  = CYC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [STEP_W-1:0]   num_steps,
    input  logic [CYC_W-1:0]    step_cycles,
    input  logic                spike_valid,
    input  logic [M1-1:0]       spike_data,
    output logic                spike_ready,
    output logic                net_reset,
    output logic                net_enable,
    output logic [M1-1:0]       net_input_spikes,
    output logic                delay_tick,
    input  logic [N2-1:0]       net_out_spikes,
    output logic                busy,
    output logic                done,
    output logic [STEP_W-1:0]   step_index,
    output logic [N2*CNT_W-1:0] spike_count,
    output logic                underrun
);
    run_state_t        state_q;
    run_state_t        state_d;
    logic [STEP_W-1:0] steps_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [1:0]        clr_cnt_q;
    logic [CYC_W-1:0]  hold_cnt_q;
    logic [STEP_W-1:0] step_next;
    logic              last_hold;
    logic              abort_run;
    logic              start_ok;
    logic              cnt_en;

    assign abort_run   = abort && (state_q != IDLE);
    assign start_ok    = start && (state_q == IDLE);
    assign last_hold   = hold_cnt_q == (cyc_q - CYC_W'(1));
    assign step_next   = step_index + STEP_W'(1);
    assign spike_ready = (state_q == FETCH) && !abort;
    assign cnt_en      = ((state_q == FETCH) || (state_q == HOLD)) && !abort;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (num_steps == '0) ? DONE : CLEAR;
            CLEAR: if (clr_cnt_q == 2'(CLEAR_CYCLES - 1)) state_d = FETCH;
            FETCH: state_d = HOLD;
            HOLD:  if (last_hold) state_d = (step_next == steps_q) ? DONE : FETCH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_run)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            steps_q          <= '0;
            cyc_q            <= '0;
            clr_cnt_q        <= '0;
            hold_cnt_q       <= '0;
            step_index       <= '0;
            underrun         <= 1'b0;
            net_input_spikes <= '0;
            net_reset        <= 1'b0;
            net_enable       <= 1'b0;
            delay_tick       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= state_d != IDLE;
            done       <= state_d == DONE;
            net_reset  <= state_d == CLEAR;
            net_enable <= (state_d == FETCH) || (state_d == HOLD);
            delay_tick <= state_d == FETCH;
            clr_cnt_q  <= (state_q == CLEAR) ? clr_cnt_q + 2'd1 : 2'd0;
            hold_cnt_q <= (state_q == HOLD) ? hold_cnt_q + CYC_W'(1) : '0;
            if (abort_run) begin
                net_input_spikes <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            steps_q    <= num_steps;
                            cyc_q      <= (step_cycles == '0) ? CYC_W'(1) : step_cycles;
                            step_index <= '0;
                            underrun   <= 1'b0;
                        end
                    end
                    CLEAR: net_input_spikes <= '0;
                    FETCH: begin
                        if (spike_valid) begin
                            net_input_spikes <= spike_data;
                        end else begin
                            net_input_spikes <= '0;
                            underrun         <= 1'b1;
                        end
                    end
                    HOLD: if (last_hold) step_index <= step_next;
                    DONE: net_input_spikes <= '0;
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < N2; i++) begin : g_cnt
        snn_spike_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clear   (start_ok),
            .prev_clr(state_q == CLEAR),
            .enable  (cnt_en),
            .spike   (net_out_spikes[i]),
            .count   (spike_count[i*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_snn_run_sequencer.sv
// Directed bench for snn_run_sequencer, with a second narrow-counter instance.
module tb_snn_run_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_steps = '0;
    logic [3:0]  step_cycles = '0;
    logic        spike_valid = 1'b0;
    logic [23:0] spike_data = '0;
    logic [1:0]  net_out_spikes = '0;

    logic        spike_ready, net_reset, net_enable, delay_tick;
    logic        busy, done, underrun;
    logic [23:0] net_input_spikes;
    logic [7:0]  step_index;
    logic [15:0] spike_count;

    logic        sat_ready, sat_reset, sat_enable, sat_tick;
    logic        sat_busy, sat_done, sat_underrun;
    logic [23:0] sat_inputs;
    logic [7:0]  sat_index;
    logic [3:0]  sat_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snn_run_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_steps(num_steps), .step_cycles(step_cycles),
        .spike_valid(spike_valid), .spike_data(spike_data),
        .spike_ready(spike_ready), .net_reset(net_reset),
        .net_enable(net_enable), .net_input_spikes(net_input_spikes),
        .delay_tick(delay_tick), .net_out_spikes(net_out_spikes),
        .busy(busy), .done(done), .step_index(step_index),
        .spike_count(spike_count), .underrun(underrun)
    );

    snn_run_sequencer #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_steps(num_steps), .step_cycles(step_cycles),
        .spike_valid(spike_valid), .spike_data(spike_data),
        .spike_ready(sat_ready), .net_reset(sat_reset),
        .net_enable(sat_enable), .net_input_spikes(sat_inputs),
        .delay_tick(sat_tick), .net_out_spikes(net_out_spikes),
        .busy(sat_busy), .done(sat_done), .step_index(sat_index),
        .spike_count(sat_count), .underrun(sat_underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {net_reset, net_enable, delay_tick, done, spike_ready, underrun}, 0);
        chk("rst_data", net_input_spikes, 0);
        chk("rst_idx", step_index, 0);
        chk("rst_cnt", spike_count, 0);
        reset = 1'b1;
        tick();

        // basic run with counting: 3 steps, 2 hold cycles
        num_steps      = 8'd3;
        step_cycles    = 4'd2;
        spike_valid    = 1'b1;
        spike_data     = 24'hFFFFFF;
        net_out_spikes = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            net_out_spikes[0] = (c == 4) || (c == 7) || (c == 10);
            chk("t1_net_reset", net_reset, c <= 2);
            chk("t1_delay_tick", delay_tick, (c == 3) || (c == 6) || (c == 9));
            chk("t1_ready", spike_ready, (c == 3) || (c == 6) || (c == 9));
            chk("t1_enable", net_enable, (c >= 3) && (c <= 11));
            chk("t1_busy", busy, 1);
            chk("t1_done", done, c == 12);
            if (c == 4)
                chk("t1_vec", net_input_spikes, 24'hFFFFFF);
            tick();
        end
        chk("t1_idle", busy, 0);
        chk("t1_idx", step_index, 3);
        chk("t1_underrun", underrun, 0);
        chk("t1_vec_clr", net_input_spikes, 0);
        chk("t1_count", spike_count, 16'h0103);
        chk("t1_sat_count", sat_count, 4'h7);

        // saturation, plus start and shadow-reg changes mid-run
        num_steps      = 8'd2;
        step_cycles    = 4'd5;
        net_out_spikes = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            net_out_spikes[0] = (c == 3) || (c == 5) || (c == 7) || (c == 9) || (c == 11);
            start = (c == 5);
            if (c == 5) begin
                num_steps   = 8'd7;
                step_cycles = 4'd0;
            end
            chk("t2_busy", busy, 1);
            chk("t2_done", done, c == 15);
            tick();
        end
        start = 1'b0;
        chk("t2_idle", busy, 0);
        chk("t2_idx", step_index, 2);
        chk("t2_count", spike_count, 16'h0005);
        chk("t2_sat_count", sat_count, 4'h3);

        // underrun on the 2nd fetch
        num_steps      = 8'd3;
        step_cycles    = 4'd1;
        spike_data     = 24'h123456;
        net_out_spikes = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            spike_valid = (c != 5);
            if (c == 4) begin
                chk("t3_vec1", net_input_spikes, 24'h123456);
                chk("t3_ur1", underrun, 0);
                chk("t3_rdy_hold", spike_ready, 0);
            end
            if (c == 5)
                chk("t3_rdy_fetch", spike_ready, 1);
            if (c == 6) begin
                chk("t3_vec2", net_input_spikes, 0);
                chk("t3_ur2", underrun, 1);
            end
            if (c == 8) begin
                chk("t3_vec3", net_input_spikes, 24'h123456);
                chk("t3_ur3", underrun, 1);
            end
            chk("t3_done", done, c == 9);
            tick();
        end
        spike_valid = 1'b1;
        chk("t3_idle", busy, 0);
        chk("t3_sticky", underrun, 1);
        chk("t3_idx", step_index, 3);

        // zero steps
        num_steps   = 8'd0;
        step_cycles = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_done", done, 1);
        chk("t4_noreset", net_reset, 0);
        chk("t4_notick", delay_tick, 0);
        chk("t4_cnt_clr", spike_count, 0);
        chk("t4_ur_clr", underrun, 0);
        tick();
        chk("t4_busy_end", busy, 0);
        chk("t4_done_end", done, 0);

        // zero step_cycles behaves as one
        num_steps   = 8'd2;
        step_cycles = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk("t5_tick", delay_tick, (c == 3) || (c == 5));
            chk("t5_done", done, c == 7);
            tick();
        end
        chk("t5_idx", step_index, 2);

        // abort during the 2nd hold
        num_steps      = 8'd3;
        step_cycles    = 4'd2;
        net_out_spikes = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) begin
                abort = 1'b1;
                net_out_spikes[0] = 1'b1;
            end
            tick();
        end
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_enable", net_enable, 0);
        chk("t6_done", done, 0);
        chk("t6_idx", step_index, 1);
        chk("t6_vec", net_input_spikes, 0);
        chk("t6_count", spike_count, 16'h0100);
        tick();
        chk("t6_no_done", done, 0);
        abort = 1'b1;
        tick();
        chk("t6_idle_abort", busy, 0);
        chk("t6_idle_idx", step_index, 1);

        // start and abort together in IDLE: start wins
        net_out_spikes = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t7_busy", busy, 1);
        chk("t7_reset", net_reset, 1);
        chk("t7_idx", step_index, 0);
        chk("t7_cnt", spike_count, 0);
        tick();
        tick();
        chk("t7_fetch", delay_tick, 1);

        // asynchronous reset mid-fetch
        #2;
        reset = 1'b0;
        #1;
        chk("t8_busy", busy, 0);
        chk("t8_ctl", {net_reset, net_enable, delay_tick, done, spike_ready, underrun}, 0);
        chk("t8_vec", net_input_spikes, 0);
        chk("t8_idx", step_index, 0);
        chk("t8_sat", {sat_ready, sat_reset, sat_enable, sat_tick, sat_busy, sat_done,
                       sat_underrun, sat_inputs, sat_index, sat_count}, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t8_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
